// File: rtl/door_timer_ctrl_pkg.sv
// Shared definitions for the elevator door sequencer: state encodings,
// counter widths and the saturating dwell decrement.
package door_timer_ctrl_pkg;

    localparam int SEG_W    = 4;
    localparam int PHS_W    = 4;
    localparam int REOPEN_W = 3;

    typedef enum logic [2:0] {
        ST_CERRADA  = 3'd0,
        ST_ABRIENDO = 3'd1,
        ST_ABIERTA  = 3'd2,
        ST_CERRANDO = 3'd3,
        ST_FALLA    = 3'd4
    } door_state_e;

    // Dwell countdown that holds at zero instead of wrapping
    function automatic logic [SEG_W-1:0] dwell_dec(input logic [SEG_W-1:0] v);
        return (v == {SEG_W{1'b0}}) ? {SEG_W{1'b0}} : (v - SEG_W'(1'b1));
    endfunction

endpackage

// File: rtl/door_timer_ctrl_if.sv
// Request/status bundle between the travel FSM (master) and the door
// sequencer (slave).
interface door_timer_ctrl_if;
    import door_timer_ctrl_pkg::*;

    logic             Abrir_Req;
    logic             Boton_Cerrar;
    logic             Sensor_Obst;
    logic             Motor_Abrir;
    logic             Motor_Cerrar;
    logic             Puerta_Cerrada;
    logic [SEG_W-1:0] Seg_Restantes;
    logic             Falla;

    modport master (
        output Abrir_Req, Boton_Cerrar, Sensor_Obst,
        input  Motor_Abrir, Motor_Cerrar, Puerta_Cerrada, Seg_Restantes, Falla
    );

    modport slave (
        input  Abrir_Req, Boton_Cerrar, Sensor_Obst,
        output Motor_Abrir, Motor_Cerrar, Puerta_Cerrada, Seg_Restantes, Falla
    );
endinterface

// File: rtl/door_timer_ctrl_chk.sv
// Simulation checker: the two door motor drives must never be on together.
module door_timer_ctrl_chk (
    input logic clk,
    input logic rst,
    input logic motor_abrir,
    input logic motor_cerrar
);
    a_motor_excl: assert property (@(posedge clk) disable iff (rst) !(motor_abrir && motor_cerrar));
endmodule

// File: rtl/door_timer_ctrl_tick_gen.sv
// Prescaler producing a one-cycle Tick every CLK_HZ/TICK_HZ cycles, with a
// synchronous clear so a new phase always starts with a full period.
module tick_gen #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 1
) (
    input  logic C_100Mhz,
    input  logic Reset,
    input  logic Clr,
    output logic Tick
);
    localparam int TICK_DIV = (TICK_HZ > 0) ? (CLK_HZ / TICK_HZ) : 2;
    localparam int CNT_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(TICK_DIV - 2);

    logic [CNT_W-1:0] cnt_r;
    logic             tick_r;

    // Count 0..TICK_DIV-1; Tick is registered so it is high exactly while cnt_r == CNT_MAX
    always_ff @(posedge C_100Mhz) begin
        if (Reset) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else if (Clr || (cnt_r == CNT_MAX)) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_r + CNT_W'(1'b1);
            tick_r <= (cnt_r == CNT_PRE);
        end
    end

    assign Tick = tick_r;
endmodule

// File: rtl/door_timer_ctrl.sv
// Elevator door sequencer: opens on request, dwells, closes, reopens on
// obstruction and latches a fault after REOPEN_MAX consecutive aborted closes.
module door_timer_ctrl
    import door_timer_ctrl_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int TICK_HZ    = 1,
    parameter int OPEN_S     = 10,
    parameter int MOVE_S     = 2,
    parameter int REOPEN_MAX = 3
) (
    input  logic             C_100Mhz,
    input  logic             Reset,
    door_timer_ctrl_if.slave bus
);
    localparam int TICK_DIV = (TICK_HZ > 0) ? (CLK_HZ / TICK_HZ) : 0;
    localparam logic [SEG_W-1:0]    OPEN_SEG   = SEG_W'(OPEN_S);
    localparam logic [PHS_W-1:0]    PHS_LAST   = PHS_W'(MOVE_S - 1);
    localparam logic [REOPEN_W-1:0] REOPEN_LIM = REOPEN_W'(REOPEN_MAX);

    if ((TICK_HZ < 1) || (TICK_DIV < 2) || (OPEN_S < 1) || (OPEN_S > 15) ||
        (MOVE_S < 1) || (MOVE_S > 15) || (REOPEN_MAX < 1) || (REOPEN_MAX > 7)) begin : g_param_check
        $error("door_timer_ctrl: parameter out of range");
    end

    door_state_e         state_r, state_nxt_s;
    logic [PHS_W-1:0]    phs_r, phs_nxt_s;
    logic [SEG_W-1:0]    seg_r, seg_nxt_s;
    logic [REOPEN_W-1:0] reopen_r, reopen_nxt_s;
    logic                tick_s, clr_s;
    logic                motor_abrir_r, motor_cerrar_r, puerta_cerrada_r, falla_r;

    assign clr_s = (state_nxt_s != state_r);

    tick_gen #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) u_tick (
        .C_100Mhz (C_100Mhz),
        .Reset    (Reset),
        .Clr      (clr_s),
        .Tick     (tick_s)
    );

    // Next state and counter updates; obstruction/request outranks everything else
    always_comb begin
        state_nxt_s  = state_r;
        phs_nxt_s    = phs_r;
        seg_nxt_s    = seg_r;
        reopen_nxt_s = reopen_r;
        case (state_r)
            ST_CERRADA: begin
                if (bus.Abrir_Req) begin
                    state_nxt_s = ST_ABRIENDO;
                    phs_nxt_s   = '0;
                end else begin
                    state_nxt_s = ST_CERRADA;
                end
            end
            ST_ABRIENDO: begin
                if (tick_s && (phs_r == PHS_LAST)) begin
                    state_nxt_s = ST_ABIERTA;
                    phs_nxt_s   = '0;
                    seg_nxt_s   = OPEN_SEG;
                end else if (tick_s) begin
                    phs_nxt_s = phs_r + PHS_W'(1'b1);
                end else begin
                    phs_nxt_s = phs_r;
                end
            end
            ST_ABIERTA: begin
                if (bus.Sensor_Obst || bus.Abrir_Req) begin
                    seg_nxt_s = OPEN_SEG;
                end else if (bus.Boton_Cerrar || (tick_s && (dwell_dec(seg_r) == '0))) begin
                    state_nxt_s = ST_CERRANDO;
                    seg_nxt_s   = '0;
                end else if (tick_s) begin
                    seg_nxt_s = dwell_dec(seg_r);
                end else begin
                    seg_nxt_s = seg_r;
                end
            end
            ST_CERRANDO: begin
                if (bus.Sensor_Obst || bus.Abrir_Req) begin
                    reopen_nxt_s = reopen_r + REOPEN_W'(1'b1);
                    phs_nxt_s    = '0;
                    if (reopen_nxt_s == REOPEN_LIM) begin
                        state_nxt_s = ST_FALLA;
                    end else begin
                        state_nxt_s = ST_ABRIENDO;
                    end
                end else if (tick_s && (phs_r == PHS_LAST)) begin
                    state_nxt_s  = ST_CERRADA;
                    phs_nxt_s    = '0;
                    reopen_nxt_s = '0;
                end else if (tick_s) begin
                    phs_nxt_s = phs_r + PHS_W'(1'b1);
                end else begin
                    phs_nxt_s = phs_r;
                end
            end
            ST_FALLA: begin
                state_nxt_s = ST_FALLA;
            end
            default: begin
                state_nxt_s = ST_FALLA;
                phs_nxt_s   = '0;
                seg_nxt_s   = '0;
            end
        endcase
    end

    // State register
    always_ff @(posedge C_100Mhz) begin
        if (Reset) begin
            state_r <= ST_CERRADA;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Phase, dwell and reopen counters
    always_ff @(posedge C_100Mhz) begin
        if (Reset) begin
            phs_r    <= '0;
            seg_r    <= '0;
            reopen_r <= '0;
        end else begin
            phs_r    <= phs_nxt_s;
            seg_r    <= seg_nxt_s;
            reopen_r <= reopen_nxt_s;
        end
    end

    // Outputs decoded from the upcoming state so they change on the same edge
    always_ff @(posedge C_100Mhz) begin
        if (Reset) begin
            motor_abrir_r    <= 1'b0;
            motor_cerrar_r   <= 1'b0;
            puerta_cerrada_r <= 1'b1;
            falla_r          <= 1'b0;
        end else begin
            motor_abrir_r    <= (state_nxt_s == ST_ABRIENDO);
            motor_cerrar_r   <= (state_nxt_s == ST_CERRANDO);
            puerta_cerrada_r <= (state_nxt_s == ST_CERRADA);
            falla_r          <= (state_nxt_s == ST_FALLA);
        end
    end

    assign bus.Motor_Abrir    = motor_abrir_r;
    assign bus.Motor_Cerrar   = motor_cerrar_r;
    assign bus.Puerta_Cerrada = puerta_cerrada_r;
    assign bus.Seg_Restantes  = seg_r;
    assign bus.Falla          = falla_r;

    door_timer_ctrl_chk u_chk (
        .clk          (C_100Mhz),
        .rst          (Reset),
        .motor_abrir  (motor_abrir_r),
        .motor_cerrar (motor_cerrar_r)
    );
endmodule
